// File: rtl/ex_muldiv_unit_if.sv
// Handshake/bus bundle between the ID/EX pipeline register, the hazard unit and the EX-stage mul/div unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       MD_Op_E;
    logic [WIDTH-1:0] SrcA_E;
    logic [WIDTH-1:0] SrcB_E;
    logic             MD_Read_E;
    logic             MD_Stall;
    logic             MD_Busy;
    logic [WIDTH-1:0] HI_E;
    logic [WIDTH-1:0] LO_E;
    logic             DivZero;

    modport master (
        output MD_Op_E, SrcA_E, SrcB_E, MD_Read_E,
        input  MD_Stall, MD_Busy, HI_E, LO_E, DivZero
    );

    modport slave (
        input  MD_Op_E, SrcA_E, SrcB_E, MD_Read_E,
        output MD_Stall, MD_Busy, HI_E, LO_E, DivZero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// state | meaning
// IDLE  | HI/LO stable, accepts MULT/MULTU/DIV/DIVU start and MTHI/MTLO writes
// ITER  | one shift-add or restoring-subtract step per cycle, WIDTH steps
// FIX   | sign fixup, HI/LO write, DivZero pulse, busy drops
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ex_muldiv_unit_if.slave       md
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     m_q, src_a_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 div_q, qneg_q, rneg_q, dz_q, busy_q, divzero_q;

    logic                 op_mul, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b, quot_fix, rem_fix;
    logic [WIDTH:0]       mul_sum, div_rs, div_diff;
    logic [2*WIDTH-1:0]   p_step, prod_fix;

    always_comb begin
        op_mul    = (md.MD_Op_E == 3'd1) || (md.MD_Op_E == 3'd2);
        op_div    = (md.MD_Op_E == 3'd3) || (md.MD_Op_E == 3'd4);
        op_signed = (md.MD_Op_E == 3'd1) || (md.MD_Op_E == 3'd3);
        a_neg     = op_signed & md.SrcA_E[WIDTH-1];
        b_neg     = op_signed & md.SrcB_E[WIDTH-1];
        abs_a     = a_neg ? -md.SrcA_E : md.SrcA_E;
        abs_b     = b_neg ? -md.SrcB_E : md.SrcB_E;

        // P holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        div_rs    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_rs - {1'b0, m_q};
        if (div_q)
            p_step = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else
            p_step = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};

        prod_fix  = qneg_q ? -p_q : p_q;
        quot_fix  = qneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem_fix   = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            src_a_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            p_q       <= '0;
            div_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_mul || op_div) begin
                        busy_q  <= 1'b1;
                        div_q   <= op_div;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        dz_q    <= op_div && (md.SrcB_E == '0);
                        src_a_q <= md.SrcA_E;
                        cnt_q   <= '0;
                        if (op_div) begin
                            m_q     <= abs_b;
                            p_q     <= {{WIDTH{1'b0}}, abs_a};
                            state_q <= S_ITER;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            m_q     <= abs_a;
                            p_q     <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                            state_q <= S_FIX;
`else
                            m_q     <= abs_a;
                            p_q     <= {{WIDTH{1'b0}}, abs_b};
                            state_q <= S_ITER;
`endif
                        end
                    end else if (md.MD_Op_E == 3'd5) begin
                        hi_q <= md.SrcA_E;
                    end else if (md.MD_Op_E == 3'd6) begin
                        lo_q <= md.SrcA_E;
                    end
                end
                S_ITER: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (dz_q) begin
                        lo_q      <= '1;
                        hi_q      <= src_a_q;
                        divzero_q <= 1'b1;
                    end else begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign md.MD_Stall = busy_q && ((md.MD_Op_E != 3'd0 && md.MD_Op_E != 3'd7) || md.MD_Read_E);
    assign md.MD_Busy  = busy_q;
    assign md.HI_E     = hi_q;
    assign md.LO_E     = lo_q;
    assign md.DivZero  = divzero_q;
endmodule
